// File: rtl/video_vram_pkg.sv
// Shared types and constants for the PPU host-side VRAM/palette access engine.
// Palette-index mirroring is shared here so every user agrees on the backdrop aliases.
package video_vram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT    = 2'd1;
    localparam state_t ST_ACCESS  = 2'd2;
    localparam state_t ST_CAPTURE = 2'd3;

    typedef enum logic {
        KIND_WR = 1'b0,
        KIND_RD = 1'b1
    } kind_t;

    localparam logic [5:0]  PAL_PAGE       = 6'h3F;
    localparam logic [13:0] NT_MIRROR_MASK = 14'h2FFF;
    localparam logic [14:0] INC_ACROSS     = 15'd1;
    localparam logic [14:0] INC_DOWN       = 15'd32;

    // Sprite backdrop entries 10/14/18/1C alias the background backdrops 00/04/08/0C.
    function automatic logic [4:0] pal_mirror(input logic [4:0] idx);
        pal_mirror = (idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;
    endfunction

endpackage

// File: rtl/video_scroll_regs.sv
// Loopy-style scroll state: temporary address t, current address v, fine-x and the shared write toggle.
// Writes are applied in order within one cycle, so a PPUSTATUS read clears the toggle before a coincident write sees it.
module video_scroll_regs
    import video_vram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        wr_ctrl,
    input  logic        wr_scrl,
    input  logic        wr_addr,
    input  logic        rd_stat,
    input  logic        inc,
    output logic [13:0] v,
    output logic [14:0] t,
    output logic [2:0]  fine_x
);

    logic [14:0] t_q, t_d;
    logic [14:0] v_q, v_d;
    logic [2:0]  fx_q, fx_d;
    logic        w_q, w_d, w_eff;
    logic        inc32_q, inc32_d;

    always_comb begin
        t_d     = t_q;
        v_d     = v_q;
        fx_d    = fx_q;
        inc32_d = inc32_q;
        w_eff   = w_q & ~rd_stat;
        w_d     = w_eff;

        if (inc) begin
            v_d = v_q + (inc32_q ? INC_DOWN : INC_ACROSS);
        end

        if (wr_ctrl) begin
            t_d[11:10] = data[1:0];
            inc32_d    = data[2];
        end

        if (wr_scrl) begin
            if (!w_eff) begin
                t_d[4:0] = data[7:3];
                fx_d     = data[2:0];
                w_d      = 1'b1;
            end else begin
                t_d[14:12] = data[2:0];
                t_d[9:5]   = data[7:3];
                w_d        = 1'b0;
            end
        end else if (wr_addr) begin
            if (!w_eff) begin
                t_d[13:8] = data[5:0];
                t_d[14]   = 1'b0;
                w_d       = 1'b1;
            end else begin
                // A completed address load wins over a coincident increment.
                t_d[7:0] = data;
                v_d      = t_d;
                w_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q     <= '0;
            v_q     <= '0;
            fx_q    <= '0;
            w_q     <= 1'b0;
            inc32_q <= 1'b0;
        end else begin
            t_q     <= t_d;
            v_q     <= v_d;
            fx_q    <= fx_d;
            w_q     <= w_d;
            inc32_q <= inc32_d;
        end
    end

    assign v      = v_q[13:0];
    assign t      = t_q;
    assign fine_x = fx_q;

endmodule

// File: rtl/video_vram_port.sv
// Host PPUDATA access engine: buffered reads, auto-increment, palette writes and
// arbitration of host cycles onto the VRAM bus whenever the renderer leaves it free.
module video_vram_port
    import video_vram_pkg::*;
#(
    parameter int P_addr_width = 14,
    parameter int P_pal_width  = 6
) (
    input  logic                    I_clock,
    input  logic                    I_reset,
    input  logic [7:0]              I_host_data,
    input  logic                    I_wr_ctrl,
    input  logic                    I_wr_scrl,
    input  logic                    I_wr_addr,
    input  logic                    I_wr_data,
    input  logic                    I_rd_data,
    input  logic                    I_rd_stat,
    input  logic                    I_vid_free,
    output logic [P_addr_width-1:0] O_vid_addr,
    output logic                    O_vid_wren,
    input  logic [7:0]              I_vid_data,
    output logic [7:0]              O_vid_data,
    output logic [4:0]              O_pal_addr,
    output logic                    O_pal_wren,
    output logic [P_pal_width-1:0]  O_pal_data,
    input  logic [P_pal_width-1:0]  I_pal_data,
    output logic [7:0]              O_host_data,
    output logic [14:0]             O_scroll_t,
    output logic [2:0]              O_fine_x,
    output logic                    O_busy,
    output logic                    O_overrun
);

    state_t                  state;
    kind_t                   kind;
    logic [13:0]             v;
    logic [13:0]             access_addr;
    logic [13:0]             addr_hold;
    logic [7:0]              wr_hold;
    logic [7:0]              rd_buf;
    logic [7:0]              host_q;
    logic                    pal_wren_q;
    logic [P_pal_width-1:0]  pal_data_q;
    logic [4:0]              pal_addr_q;
    logic                    overrun_q;
    logic                    pal_region;
    logic                    busy;
    logic                    inc;

    assign pal_region = (v[13:8] == PAL_PAGE);
    assign busy       = (state != ST_IDLE);

    // Palette-page reads still fetch the nametable byte underneath into the read buffer.
    assign access_addr = (kind == KIND_RD && pal_region) ? (v & NT_MIRROR_MASK) : v;

    assign inc = (state == ST_ACCESS && kind == KIND_WR)
               || (state == ST_CAPTURE)
               || (state == ST_IDLE && I_wr_data && pal_region);

    video_scroll_regs u_scroll (
        .clk     (I_clock),
        .rst_n   (I_reset),
        .data    (I_host_data),
        .wr_ctrl (I_wr_ctrl),
        .wr_scrl (I_wr_scrl),
        .wr_addr (I_wr_addr),
        .rd_stat (I_rd_stat),
        .inc     (inc),
        .v       (v),
        .t       (O_scroll_t),
        .fine_x  (O_fine_x)
    );

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state      <= ST_IDLE;
            kind       <= KIND_WR;
            addr_hold  <= '0;
            wr_hold    <= '0;
            rd_buf     <= '0;
            host_q     <= '0;
            pal_wren_q <= 1'b0;
            pal_data_q <= '0;
            pal_addr_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            pal_wren_q <= 1'b0;
            overrun_q  <= busy & (I_wr_data | I_rd_data);
            case (state)
                ST_IDLE: begin
                    if (I_wr_data) begin
                        if (pal_region) begin
                            // v advances on this edge, so the write address is latched separately.
                            pal_wren_q <= 1'b1;
                            pal_data_q <= I_host_data[P_pal_width-1:0];
                            pal_addr_q <= pal_mirror(v[4:0]);
                        end else begin
                            wr_hold <= I_host_data;
                            kind    <= KIND_WR;
                            state   <= ST_WAIT;
                        end
                    end else if (I_rd_data) begin
                        host_q <= pal_region ? 8'(I_pal_data) : rd_buf;
                        kind   <= KIND_RD;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (I_vid_free) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    addr_hold <= access_addr;
                    state     <= (kind == KIND_RD) ? ST_CAPTURE : ST_IDLE;
                end
                ST_CAPTURE: begin
                    rd_buf <= I_vid_data;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign O_vid_addr  = P_addr_width'((state == ST_ACCESS) ? access_addr : addr_hold);
    assign O_vid_wren  = (state == ST_ACCESS) && (kind == KIND_WR);
    assign O_vid_data  = wr_hold;
    assign O_pal_addr  = pal_wren_q ? pal_addr_q : pal_mirror(v[4:0]);
    assign O_pal_wren  = pal_wren_q;
    assign O_pal_data  = pal_data_q;
    assign O_host_data = host_q;
    assign O_busy      = busy;
    assign O_overrun   = overrun_q;

endmodule

// File: tb/tb_video_vram_port.sv
// Self-checking bench for video_vram_port: register table, directed corner sequences,
// and randomized host traffic compared against a transaction-level PPU model.
module tb_video_vram_port;

    localparam int OP_CTRL      = 0;
    localparam int OP_SCRL      = 1;
    localparam int OP_ADDR      = 2;
    localparam int OP_STAT      = 3;
    localparam int OP_STAT_ADDR = 4;
    localparam int OP_WR        = 5;
    localparam int OP_RD        = 6;

    typedef struct {
        int          op;
        logic [7:0]  data;
        logic [14:0] expT;
        logic [2:0]  expFx;
    } regVector_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic [7:0]  hostDataIn;
    logic        wrCtrl, wrScrl, wrAddr, wrData, rdData, rdStat;
    logic        vidFree;
    logic [13:0] vidAddr;
    logic        vidWren;
    logic [7:0]  vidRdata;
    logic [7:0]  vidWdata;
    logic [4:0]  palAddr;
    logic        palWren;
    logic [5:0]  palData;
    logic [5:0]  palRdata;
    logic [7:0]  hostDataOut;
    logic [14:0] scrollT;
    logic [2:0]  fineX;
    logic        busy;
    logic        overrun;

    int assertCount = 0;
    int failCount   = 0;
    bit freeRandom  = 1'b0;

    logic [7:0]  vram   [0:16383];
    logic [5:0]  palMem [0:31];
    bit          memReady      = 1'b0;
    int          wrenCount     = 0;
    logic [13:0] lastWrAddr    = '0;
    logic [7:0]  lastWrData    = '0;

    logic [7:0]  refVram [0:16383];
    logic [5:0]  refPal  [0:31];
    logic [14:0] mV, mT;
    logic [2:0]  mFx;
    logic        mW, mInc32;
    logic [7:0]  mBuf, mHost;

    always #5 clock = ~clock;

    video_vram_port dut (
        .I_clock     (clock),
        .I_reset     (resetN),
        .I_host_data (hostDataIn),
        .I_wr_ctrl   (wrCtrl),
        .I_wr_scrl   (wrScrl),
        .I_wr_addr   (wrAddr),
        .I_wr_data   (wrData),
        .I_rd_data   (rdData),
        .I_rd_stat   (rdStat),
        .I_vid_free  (vidFree),
        .O_vid_addr  (vidAddr),
        .O_vid_wren  (vidWren),
        .I_vid_data  (vidRdata),
        .O_vid_data  (vidWdata),
        .O_pal_addr  (palAddr),
        .O_pal_wren  (palWren),
        .O_pal_data  (palData),
        .I_pal_data  (palRdata),
        .O_host_data (hostDataOut),
        .O_scroll_t  (scrollT),
        .O_fine_x    (fineX),
        .O_busy      (busy),
        .O_overrun   (overrun)
    );

    // VRAM and palette RAM environment; read data follows the address by one cycle.
    always @(posedge clock) begin
        if (!memReady) begin
            for (int i = 0; i < 16384; i++) vram[i] <= 8'h00;
            for (int i = 0; i < 32; i++) palMem[i] <= 6'h00;
            memReady <= 1'b1;
        end else begin
            if (vidWren) begin
                vram[vidAddr] <= vidWdata;
                wrenCount     <= wrenCount + 1;
                lastWrAddr    <= vidAddr;
                lastWrData    <= vidWdata;
            end
            if (palWren) palMem[palAddr] <= palData;
            vidRdata <= vram[vidAddr];
        end
    end

    assign palRdata = palMem[palAddr];

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        if (freeRandom) vidFree = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int op, input logic [7:0] d);
        hostDataIn = d;
        wrCtrl = (op == OP_CTRL);
        wrScrl = (op == OP_SCRL);
        wrAddr = (op == OP_ADDR) || (op == OP_STAT_ADDR);
        rdStat = (op == OP_STAT) || (op == OP_STAT_ADDR);
        wrData = (op == OP_WR);
        rdData = (op == OP_RD);
        tick();
        {wrCtrl, wrScrl, wrAddr, rdStat, wrData, rdData} = '0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        tick();
        while (busy && n < 300) begin
            tick();
            n++;
        end
        checkOutput({name, " idle"}, 32'(busy), 32'h0);
    endtask

    task automatic doReset();
        {wrCtrl, wrScrl, wrAddr, rdStat, wrData, rdData} = '0;
        hostDataIn = 8'h00;
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
        mV = '0; mT = '0; mFx = '0; mW = 1'b0; mInc32 = 1'b0; mBuf = '0; mHost = '0;
    endtask

    function automatic logic [4:0] refPalIndex(input logic [14:0] addr);
        int idx = int'(addr[4:0]);
        if (idx >= 16 && idx % 4 == 0) idx = idx - 16;
        return 5'(idx);
    endfunction

    // Transaction-level model of one host register access.
    task automatic modelOp(input int op, input logic [7:0] d);
        bit palPage = (mV[13:8] == 6'h3F);
        int step    = mInc32 ? 32 : 1;
        case (op)
            OP_CTRL: begin
                mT[11:10] = d[1:0];
                mInc32    = d[2];
            end
            OP_SCRL: begin
                if (!mW) begin mT[4:0] = d[7:3]; mFx = d[2:0]; end
                else begin mT[14:12] = d[2:0]; mT[9:5] = d[7:3]; end
                mW = ~mW;
            end
            OP_STAT: mW = 1'b0;
            OP_ADDR, OP_STAT_ADDR: begin
                if (op == OP_STAT_ADDR) mW = 1'b0;
                if (!mW) begin mT[13:8] = d[5:0]; mT[14] = 1'b0; end
                else begin mT[7:0] = d; mV = mT; end
                mW = ~mW;
            end
            OP_WR: begin
                if (palPage) refPal[refPalIndex(mV)] = d[5:0];
                else refVram[mV[13:0]] = d;
                mV = 15'((int'(mV) + step) % 32768);
            end
            OP_RD: begin
                mHost = palPage ? {2'b00, refPal[refPalIndex(mV)]} : mBuf;
                mBuf  = refVram[palPage ? (mV[13:0] & 14'h2FFF) : mV[13:0]];
                mV    = 15'((int'(mV) + step) % 32768);
            end
            default: ;
        endcase
    endtask

    initial begin
        regVector_t vecs[14];
        int          wcSnap;
        bit          sawWren;
        int          memErrs;
        logic [7:0]  highSel[5];

        vecs[0]  = '{OP_SCRL,      8'h7D, 15'h000F, 3'd5};
        vecs[1]  = '{OP_SCRL,      8'h5E, 15'h616F, 3'd5};
        vecs[2]  = '{OP_CTRL,      8'h03, 15'h6D6F, 3'd5};
        vecs[3]  = '{OP_ADDR,      8'h21, 15'h216F, 3'd5};
        vecs[4]  = '{OP_STAT,      8'h00, 15'h216F, 3'd5};
        vecs[5]  = '{OP_ADDR,      8'h3F, 15'h3F6F, 3'd5};
        vecs[6]  = '{OP_ADDR,      8'h08, 15'h3F08, 3'd5};
        vecs[7]  = '{OP_CTRL,      8'h00, 15'h3308, 3'd5};
        vecs[8]  = '{OP_SCRL,      8'hFF, 15'h331F, 3'd7};
        vecs[9]  = '{OP_SCRL,      8'h00, 15'h001F, 3'd7};
        vecs[10] = '{OP_SCRL,      8'h00, 15'h0000, 3'd0};
        vecs[11] = '{OP_STAT_ADDR, 8'h25, 15'h2500, 3'd0};
        vecs[12] = '{OP_ADDR,      8'h80, 15'h2580, 3'd0};
        vecs[13] = '{OP_CTRL,      8'h07, 15'h2D80, 3'd0};

        vidFree = 1'b1;
        doReset();

        checkOutput("reset host_data", 32'(hostDataOut), 32'h0);
        checkOutput("reset busy",      32'(busy),        32'h0);
        checkOutput("reset vid_wren",  32'(vidWren),     32'h0);
        checkOutput("reset overrun",   32'(overrun),     32'h0);
        checkOutput("reset pal_wren",  32'(palWren),     32'h0);
        checkOutput("reset scroll_t",  32'(scrollT),     32'h0);
        checkOutput("reset fine_x",    32'(fineX),       32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].data);
            checkOutput($sformatf("table[%0d] scroll_t", i), 32'(scrollT), 32'(vecs[i].expT));
            checkOutput($sformatf("table[%0d] fine_x", i),   32'(fineX),   32'(vecs[i].expFx));
        end

        // Randomized traffic from a clean reset, with the bus randomly granted.
        doReset();
        for (int i = 0; i < 16384; i++) refVram[i] = 8'h00;
        for (int i = 0; i < 32; i++) refPal[i] = 6'h00;
        highSel = '{8'h20, 8'h21, 8'h23, 8'h3F, 8'h00};
        freeRandom = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int          r  = int'($urandom_range(0, 10));
            int          op;
            logic [7:0]  d  = 8'($urandom);
            case (r)
                0:       op = OP_CTRL;
                1, 2:    op = OP_SCRL;
                3, 4:    op = OP_ADDR;
                5:       op = OP_STAT;
                6:       op = OP_STAT_ADDR;
                7, 8:    op = OP_WR;
                default: op = OP_RD;
            endcase
            if ((op == OP_ADDR && !mW) || op == OP_STAT_ADDR) begin
                int k = int'($urandom_range(0, 4));
                if (k < 4) d = highSel[k];
            end
            applyStimulus(op, d);
            modelOp(op, d);
            waitIdle($sformatf("rand[%0d]", n));
            checkOutput($sformatf("rand[%0d] scroll_t", n), 32'(scrollT), 32'(mT));
            checkOutput($sformatf("rand[%0d] fine_x", n),   32'(fineX),   32'(mFx));
            if (op == OP_RD)
                checkOutput($sformatf("rand[%0d] host_data", n), 32'(hostDataOut), 32'(mHost));
        end
        freeRandom = 1'b0;
        vidFree = 1'b1;
        memErrs = 0;
        for (int i = 0; i < 16384; i++) if (vram[i] !== refVram[i]) memErrs++;
        checkOutput("rand vram mismatching bytes", 32'(memErrs), 32'h0);
        memErrs = 0;
        for (int i = 0; i < 32; i++) if (palMem[i] !== refPal[i]) memErrs++;
        checkOutput("rand palette mismatching entries", 32'(memErrs), 32'h0);

        // Plain VRAM write and follow-on increment.
        doReset();
        applyStimulus(OP_ADDR, 8'h21);
        applyStimulus(OP_ADDR, 8'h08);
        wcSnap = wrenCount;
        applyStimulus(OP_WR, 8'h5A);
        waitIdle("write1");
        checkOutput("write1 count", 32'(wrenCount - wcSnap), 32'd1);
        checkOutput("write1 addr",  32'(lastWrAddr), 32'h2108);
        checkOutput("write1 data",  32'(lastWrData), 32'h5A);
        applyStimulus(OP_WR, 8'h77);
        waitIdle("write2");
        checkOutput("write2 addr", 32'(lastWrAddr), 32'h2109);

        // Buffered reads with +32 stepping.
        doReset();
        applyStimulus(OP_CTRL, 8'h04);
        applyStimulus(OP_ADDR, 8'h20);
        applyStimulus(OP_ADDR, 8'h00);
        applyStimulus(OP_WR, 8'hAA);
        waitIdle("preload AA");
        applyStimulus(OP_WR, 8'hBB);
        waitIdle("preload BB");
        checkOutput("preload BB addr", 32'(lastWrAddr), 32'h2020);
        applyStimulus(OP_ADDR, 8'h20);
        applyStimulus(OP_ADDR, 8'h00);
        applyStimulus(OP_RD, 8'h00);
        checkOutput("read1 host_data", 32'(hostDataOut), 32'h00);
        waitIdle("read1");
        applyStimulus(OP_RD, 8'h00);
        checkOutput("read2 host_data", 32'(hostDataOut), 32'hAA);
        waitIdle("read2");
        applyStimulus(OP_WR, 8'h11);
        waitIdle("write after reads");
        checkOutput("v after reads", 32'(lastWrAddr), 32'h2040);

        // Palette write bypasses the VRAM bus; palette read is immediate.
        doReset();
        applyStimulus(OP_ADDR, 8'h3F);
        applyStimulus(OP_ADDR, 8'h10);
        wcSnap = wrenCount;
        applyStimulus(OP_WR, 8'h2C);
        checkOutput("pal wren",   32'(palWren), 32'h1);
        checkOutput("pal addr",   32'(palAddr), 32'h00);
        checkOutput("pal data",   32'(palData), 32'h2C);
        checkOutput("pal busy",   32'(busy),    32'h0);
        tick();
        checkOutput("pal wren one cycle", 32'(palWren), 32'h0);
        applyStimulus(OP_WR, 8'h15);
        checkOutput("pal 3F11 addr", 32'(palAddr), 32'h11);
        tick();
        checkOutput("pal no vram write", 32'(wrenCount - wcSnap), 32'd0);
        applyStimulus(OP_ADDR, 8'h3F);
        applyStimulus(OP_ADDR, 8'h00);
        applyStimulus(OP_RD, 8'h00);
        checkOutput("pal read host_data", 32'(hostDataOut), 32'h2C);
        waitIdle("pal read");
        checkOutput("pal read vram addr", 32'(vidAddr), 32'h2F00);

        // Stalled bus, dropped second strobe, single write on grant.
        doReset();
        applyStimulus(OP_ADDR, 8'h21);
        applyStimulus(OP_ADDR, 8'h00);
        vidFree = 1'b0;
        wcSnap = wrenCount;
        applyStimulus(OP_WR, 8'h33);
        sawWren = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vidWren || !busy) sawWren = 1'b1;
        end
        checkOutput("stall busy held, no wren", 32'(sawWren), 32'h0);
        applyStimulus(OP_WR, 8'h44);
        checkOutput("overrun pulse", 32'(overrun), 32'h1);
        tick();
        checkOutput("overrun cleared", 32'(overrun), 32'h0);
        vidFree = 1'b1;
        waitIdle("stall release");
        checkOutput("stall write count", 32'(wrenCount - wcSnap), 32'd1);
        checkOutput("stall write data",  32'(lastWrData), 32'h33);
        checkOutput("stall write addr",  32'(lastWrAddr), 32'h2100);
        applyStimulus(OP_WR, 8'h45);
        waitIdle("after drop");
        checkOutput("dropped strobe left v", 32'(lastWrAddr), 32'h2101);

        // Reset while an access waits for the bus.
        doReset();
        applyStimulus(OP_ADDR, 8'h21);
        applyStimulus(OP_ADDR, 8'h00);
        vidFree = 1'b0;
        applyStimulus(OP_WR, 8'h55);
        checkOutput("wait busy", 32'(busy), 32'h1);
        wcSnap = wrenCount;
        #2 resetN = 1'b0;
        #1;
        checkOutput("async reset busy",     32'(busy),    32'h0);
        checkOutput("async reset vid_wren", 32'(vidWren), 32'h0);
        checkOutput("async reset scroll_t", 32'(scrollT), 32'h0);
        tick();
        resetN = 1'b1;
        vidFree = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("no access after reset", 32'(wrenCount - wcSnap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
